// File: rtl/simple_uart_pkg.sv
// Shared types and helpers for the simple UART.
// Transmitter and receiver state types live side by side.
package simple_uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // A rate faster than the clock degenerates to one clock per bit.
   function automatic int unsigned clocks_per_bit(
      input int unsigned freq,
      input int unsigned baud
   );
      if (baud == 0 || freq < baud) return 1;
      return freq / baud;
   endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: pulses bit_done once every CLOCKS_PER_BIT
// enabled cycles and holds at zero while disabled.
module baud_counter #(
   parameter int unsigned CLOCKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic bit_done
);

   localparam logic [31:0] LAST = 32'(CLOCKS_PER_BIT - 1);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;
   logic        wrap;

   assign wrap     = (cnt_q == LAST);
   assign bit_done = en && wrap;

   always_comb begin
      cnt_d = '0;
      if (en && !wrap) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/transmitter_axis.sv
// AXI-Stream fed UART transmitter: 8N1-style framing with a
// configurable word width and one or two stop bits.
module transmitter_axis
   import simple_uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
   parameter int unsigned BAUD_RATE       = 32'd115200,
   parameter int unsigned WORD_WIDTH      = 32'd8,
   parameter int unsigned STOP_BITS       = 32'd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] din_axis_tdata,
   input  logic                  din_axis_tvalid,
   output logic                  din_axis_tready,
   output logic                  dout,
   output logic                  busy
);

   localparam int unsigned CLOCKS_PER_BIT =
      clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int unsigned IDX_W =
      (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam int unsigned SIDX_W =
      (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_WIDTH - 1);
   localparam logic [SIDX_W-1:0] LAST_STOP = SIDX_W'(STOP_BITS - 1);

   tx_state_e             state_q;
   tx_state_e             state_d;
   logic [WORD_WIDTH-1:0] shreg_q;
   logic [WORD_WIDTH-1:0] shreg_d;
   logic [IDX_W-1:0]      bit_idx_q;
   logic [IDX_W-1:0]      bit_idx_d;
   logic [SIDX_W-1:0]     stop_idx_q;
   logic [SIDX_W-1:0]     stop_idx_d;
   logic                  dout_q;
   logic                  dout_d;
   logic                  bit_done;
   logic                  handshake;

   assign din_axis_tready = (state_q == TX_IDLE) && !rst;
   assign handshake       = din_axis_tvalid && din_axis_tready;
   assign busy            = (state_q != TX_IDLE);
   assign dout            = dout_q;

   baud_counter #(
      .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .en      (busy),
      .bit_done(bit_done)
   );

   // dout_d is the line level for the state being entered, so the
   // output flop never carries decode glitches onto the line.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      dout_d     = dout_q;
      unique case (state_q)
         TX_IDLE: begin
            dout_d     = 1'b1;
            bit_idx_d  = '0;
            stop_idx_d = '0;
            if (handshake) begin
               shreg_d = din_axis_tdata;
               state_d = TX_START;
               dout_d  = 1'b0;
            end
         end
         TX_START: begin
            if (bit_done) begin
               state_d   = TX_DATA;
               bit_idx_d = '0;
               dout_d    = shreg_q[0];
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               if (bit_idx_q == LAST_IDX) begin
                  state_d    = TX_STOP;
                  stop_idx_d = '0;
                  dout_d     = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shreg_d   = shreg_q >> 1;
                  dout_d    = shreg_d[0];
               end
            end
         end
         TX_STOP: begin
            if (bit_done) begin
               if (stop_idx_q == LAST_STOP) begin
                  state_d = TX_IDLE;
                  dout_d  = 1'b1;
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = TX_IDLE;
            dout_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= '0;
         dout_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         dout_q     <= dout_d;
      end
   end

endmodule

// File: doc/transmitter_axis.md
TRANSMITTER_AXIS -- requirements
Module: transmitter_axis

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQUENCY, default 32'd100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 32'd115200, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have parameter WORD_WIDTH, default 32'd8, meaning the data bits per frame.
REQ-004 The block SHALL have parameter STOP_BITS, default 32'd1, meaning the stop bits per frame (legal values 1 or 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have port din_axis_tdata, input, WORD_WIDTH bits: the word to transmit.
REQ-008 The block SHALL have port din_axis_tvalid, input, 1 bit: AXI-Stream valid from the upstream source.
REQ-009 The block SHALL have port din_axis_tready, output, 1 bit: AXI-Stream ready; the block can accept a word.
REQ-010 The block SHALL have port dout, output, 1 bit: the serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is on the line.

Function
REQ-012 CLOCKS_PER_BIT SHALL equal CLOCK_FREQUENCY / BAUD_RATE, using integer truncation.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-014 din_axis_tready SHALL be 1 only when state == IDLE and rst is low.
REQ-015 A handshake SHALL occur on a clk edge where tvalid && tready; tdata is latched into a shift register on that edge, and state goes to START.
REQ-016 tdata and tvalid SHALL be ignored outside IDLE; a word is never overwritten mid-frame.
REQ-017 dout SHALL equal 0 for exactly CLOCKS_PER_BIT cycles in START, starting the cycle after the handshake (latency 1 cycle).
REQ-018 DATA SHALL output WORD_WIDTH bits LSB first, each held for exactly CLOCKS_PER_BIT cycles.
REQ-019 After the last data bit, the state SHALL move directly to STOP.
REQ-020 STOP SHALL hold dout=1 for STOP_BITS*CLOCKS_PER_BIT cycles, then return to IDLE.
REQ-021 Total frame length SHALL be (1+WORD_WIDTH+STOP_BITS)*CLOCKS_PER_BIT cycles.
REQ-022 Frames SHALL be separated by at least 1 idle cycle, because tready reasserts in IDLE.
REQ-023 dout SHALL be 1 in IDLE.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 dout SHALL be driven from a register, with no combinational glitches.
REQ-026 The bit-period counter SHALL be 32 bits wide, count 0 to CLOCKS_PER_BIT-1, clear on wrap, and clear in IDLE.
REQ-027 The data-bit index SHALL count 0 to WORD_WIDTH-1 and the stop-bit index 0 to STOP_BITS-1; both SHALL clear on state entry.
REQ-028 If tvalid drops in the same cycle tready rises, no handshake SHALL occur and dout SHALL remain 1.

Reset
REQ-029 While rst is high, the block SHALL hold state=IDLE, dout=1, busy=0, din_axis_tready=0, and all counters and the shift register at 0.
REQ-030 Asserting rst mid-frame SHALL abort the frame immediately (asynchronously), with dout returning to 1 without waiting for a clk edge.
REQ-031 On the first clk edge after rst deasserts, tready SHALL be 1; no partial frame SHALL resume.

Structure
REQ-032 CLOCKS_PER_BIT SHALL be computed as a localparam; the state enum SHALL be a typedef in shared package simple_uart_pkg, next to the receiver's state type.
REQ-033 The block MAY instantiate one sub-module, baud_counter, which emits a one-cycle bit_done pulse every CLOCKS_PER_BIT cycles while enabled and clears when disabled; otherwise the counter SHALL be inline.

Verification (CLOCK_FREQUENCY=8, BAUD_RATE=1, so CLOCKS_PER_BIT=8, WORD_WIDTH=8 unless noted)
REQ-034 Single word: tdata=8'hA5 with tvalid for one handshake -> dout is 0 (start bit), then 1,0,1,0,0,1,0,1, then 1 (stop), each for 8 cycles; busy is high for 80 cycles; tready returns to 1 on cycle 81.
REQ-035 Back-to-back: tvalid held high with tdata=8'h00 then 8'hFF -> two frames with exactly one idle cycle between them, and exactly two handshakes counted.
REQ-036 Backpressure: tvalid asserted and tdata changed mid-frame -> the frame on the line is unchanged, and the new word is accepted only in IDLE.
REQ-037 Reset mid-frame: rst asserted during data bit 3 -> dout=1, busy=0, tready=0 with no clk edge needed; after release, tready=1 and a new word 8'h3C transmits correctly.
REQ-038 STOP_BITS=2, word 8'h81 -> the stop high lasts 16 cycles and the total frame is 88 cycles.
REQ-039 Default parameters (CLOCKS_PER_BIT=868), word 8'h55 -> each bit lasts 868 cycles; a serial monitor decodes 8'h55.
